// File: rtl/machine_control_pkg.sv
// Shared constants for the machine-mode trap sequencer: FSM encodings,
// PC-source mux selects, mcause codes and the SYSTEM opcodes it decodes.
package machine_control_pkg;

   typedef enum logic [1:0] {
      ST_RESET       = 2'd0,
      ST_OPERATING   = 2'd1,
      ST_TRAP_TAKEN  = 2'd2,
      ST_TRAP_RETURN = 2'd3
   } state_e;

   localparam logic [1:0] PC_SRC_BOOT   = 2'b00;
   localparam logic [1:0] PC_SRC_MEPC   = 2'b01;
   localparam logic [1:0] PC_SRC_VECTOR = 2'b10;
   localparam logic [1:0] PC_SRC_NEXT   = 2'b11;

   // Exception cause codes (mcause.interrupt = 0)
   localparam logic [3:0] CAUSE_MISALIGNED_INSTR = 4'd0;
   localparam logic [3:0] CAUSE_ILLEGAL_INSTR    = 4'd2;
   localparam logic [3:0] CAUSE_BREAKPOINT       = 4'd3;
   localparam logic [3:0] CAUSE_MISALIGNED_LOAD  = 4'd4;
   localparam logic [3:0] CAUSE_MISALIGNED_STORE = 4'd6;
   localparam logic [3:0] CAUSE_ECALL_M          = 4'd11;

   // Interrupt cause codes (mcause.interrupt = 1)
   localparam logic [3:0] CAUSE_M_SOFTWARE_IRQ   = 4'd3;
   localparam logic [3:0] CAUSE_M_TIMER_IRQ      = 4'd7;
   localparam logic [3:0] CAUSE_M_EXTERNAL_IRQ   = 4'd11;

   localparam logic [31:0] INSTR_ECALL  = 32'h0000_0073;
   localparam logic [31:0] INSTR_EBREAK = 32'h0010_0073;
   localparam logic [31:0] INSTR_MRET   = 32'h3020_0073;

endpackage

// File: rtl/machine_control_trap_priority_enc.sv
// Combinational trap arbiter: picks the single highest-priority trap source.
// Any exception beats any interrupt; interrupt inputs arrive already gated
// by their enable bits and the global MIE.
module trap_priority_enc
   import machine_control_pkg::*;
(
   input  logic       misaligned_instr_i,
   input  logic       illegal_instr_i,
   input  logic       is_ebreak_i,
   input  logic       is_ecall_i,
   input  logic       misaligned_load_i,
   input  logic       misaligned_store_i,
   input  logic       irq_external_i,
   input  logic       irq_software_i,
   input  logic       irq_timer_i,
   output logic       trap_valid_o,
   output logic       is_interrupt_o,
   output logic [3:0] cause_o
);

   // Fixed-priority chain, highest priority tested first
   always_comb begin
      trap_valid_o   = 1'b1;
      is_interrupt_o = 1'b0;
      cause_o        = 4'd0;
      if (misaligned_instr_i) begin
         cause_o = CAUSE_MISALIGNED_INSTR;
      end else if (illegal_instr_i) begin
         cause_o = CAUSE_ILLEGAL_INSTR;
      end else if (is_ebreak_i) begin
         cause_o = CAUSE_BREAKPOINT;
      end else if (is_ecall_i) begin
         cause_o = CAUSE_ECALL_M;
      end else if (misaligned_load_i) begin
         cause_o = CAUSE_MISALIGNED_LOAD;
      end else if (misaligned_store_i) begin
         cause_o = CAUSE_MISALIGNED_STORE;
      end else if (irq_external_i) begin
         is_interrupt_o = 1'b1;
         cause_o        = CAUSE_M_EXTERNAL_IRQ;
      end else if (irq_software_i) begin
         is_interrupt_o = 1'b1;
         cause_o        = CAUSE_M_SOFTWARE_IRQ;
      end else if (irq_timer_i) begin
         is_interrupt_o = 1'b1;
         cause_o        = CAUSE_M_TIMER_IRQ;
      end else begin
         trap_valid_o = 1'b0;
      end
   end

endmodule

// File: rtl/machine_control.sv
// Machine-mode trap sequencer: arbitrates exceptions/interrupts, sequences
// trap entry and MRET return, and drives PC-source, CSR strobes and flush.
//
// state          | meaning
// ---------------+--------------------------------------------------------
// ST_RESET       | fetch boot address, flush decode
// ST_OPERATING   | normal execution, trap/MRET decisions (frozen by stall)
// ST_TRAP_TAKEN  | one cycle: capture mepc/mcause, clear MIE, fetch vector
// ST_TRAP_RETURN | one cycle: restore MIE, fetch from mepc
module machine_control
   import machine_control_pkg::*;
(
   input  logic        clk_in,
   input  logic        rst_n_in,
   input  logic [31:0] instr_in,
   input  logic        illegal_instr_in,
   input  logic        misaligned_load_in,
   input  logic        misaligned_store_in,
   input  logic        misaligned_instr_in,
   input  logic        mie_in,
   input  logic        meie_in,
   input  logic        mtie_in,
   input  logic        msie_in,
   input  logic        meip_in,
   input  logic        mtip_in,
   input  logic        msip_in,
   input  logic        stall_in,
   output logic        trap_taken_out,
   output logic        i_or_e_out,
   output logic [3:0]  cause_out,
   output logic        set_epc_out,
   output logic        set_cause_out,
   output logic        mie_clear_out,
   output logic        mie_set_out,
   output logic [1:0]  pc_src_out,
   output logic        flush_out
);

   state_e     state_q, state_d;
   logic [3:0] cause_q;
   logic       i_or_e_q;

   logic       is_ecall, is_ebreak, is_mret;
   logic       irq_ext, irq_sw, irq_tmr;
   logic       trap_valid, trap_is_irq;
   logic [3:0] trap_cause;
   logic       take_trap;

   assign is_ecall  = (instr_in == INSTR_ECALL);
   assign is_ebreak = (instr_in == INSTR_EBREAK);
   assign is_mret   = (instr_in == INSTR_MRET);

   assign irq_ext = mie_in & meie_in & meip_in;
   assign irq_sw  = mie_in & msie_in & msip_in;
   assign irq_tmr = mie_in & mtie_in & mtip_in;

   trap_priority_enc u_prio (
      .misaligned_instr_i (misaligned_instr_in),
      .illegal_instr_i    (illegal_instr_in),
      .is_ebreak_i        (is_ebreak),
      .is_ecall_i         (is_ecall),
      .misaligned_load_i  (misaligned_load_in),
      .misaligned_store_i (misaligned_store_in),
      .irq_external_i     (irq_ext),
      .irq_software_i     (irq_sw),
      .irq_timer_i        (irq_tmr),
      .trap_valid_o       (trap_valid),
      .is_interrupt_o     (trap_is_irq),
      .cause_o            (trap_cause)
   );

   // A trap decision is only made from OPERATING while memory is ready
   assign take_trap = (state_q == ST_OPERATING) && !stall_in && trap_valid;

   // State register
   always_ff @(posedge clk_in or negedge rst_n_in) begin
      if (!rst_n_in) begin
         state_q <= ST_RESET;
      end else begin
         state_q <= state_d;
      end
   end

   // Next-state logic; a pending trap pre-empts a simultaneous MRET
   always_comb begin
      state_d = state_q;
      case (state_q)
         ST_RESET:       state_d = ST_OPERATING;
         ST_OPERATING: begin
            if (!stall_in) begin
               if (trap_valid) begin
                  state_d = ST_TRAP_TAKEN;
               end else if (is_mret) begin
                  state_d = ST_TRAP_RETURN;
               end
            end
         end
         ST_TRAP_TAKEN:  state_d = ST_OPERATING;
         ST_TRAP_RETURN: state_d = ST_OPERATING;
         default:        state_d = ST_RESET;
      endcase
   end

   // Cause / interrupt flag captured only on trap entry, held otherwise
   always_ff @(posedge clk_in or negedge rst_n_in) begin
      if (!rst_n_in) begin
         cause_q  <= 4'd0;
         i_or_e_q <= 1'b0;
      end else if (take_trap) begin
         cause_q  <= trap_cause;
         i_or_e_q <= trap_is_irq;
      end
   end

   assign cause_out  = cause_q;
   assign i_or_e_out = i_or_e_q;

   // Moore output decode from the current state
   always_comb begin
      trap_taken_out = 1'b0;
      set_epc_out    = 1'b0;
      set_cause_out  = 1'b0;
      mie_clear_out  = 1'b0;
      mie_set_out    = 1'b0;
      flush_out      = 1'b0;
      pc_src_out     = PC_SRC_NEXT;
      case (state_q)
         ST_RESET: begin
            flush_out  = 1'b1;
            pc_src_out = PC_SRC_BOOT;
         end
         ST_TRAP_TAKEN: begin
            trap_taken_out = 1'b1;
            set_epc_out    = 1'b1;
            set_cause_out  = 1'b1;
            mie_clear_out  = 1'b1;
            flush_out      = 1'b1;
            pc_src_out     = PC_SRC_VECTOR;
         end
         ST_TRAP_RETURN: begin
            mie_set_out = 1'b1;
            flush_out   = 1'b1;
            pc_src_out  = PC_SRC_MEPC;
         end
         default: begin
            pc_src_out = PC_SRC_NEXT;
         end
      endcase
   end

endmodule

// File: tb/tb_machine_control.sv
// Self-checking bench for machine_control: directed scenarios followed by a
// randomized run, all compared against a behavioural trap model.
module tb_machine_control;

   logic        clk_in = 1'b0;
   logic        rst_n_in;
   logic [31:0] instr_in;
   logic        illegal_instr_in, misaligned_load_in, misaligned_store_in, misaligned_instr_in;
   logic        mie_in, meie_in, mtie_in, msie_in, meip_in, mtip_in, msip_in;
   logic        stall_in;
   logic        trap_taken_out, i_or_e_out, set_epc_out, set_cause_out;
   logic        mie_clear_out, mie_set_out, flush_out;
   logic [3:0]  cause_out;
   logic [1:0]  pc_src_out;

   localparam logic [31:0] ECALL  = 32'h0000_0073;
   localparam logic [31:0] EBREAK = 32'h0010_0073;
   localparam logic [31:0] MRET   = 32'h3020_0073;
   localparam logic [31:0] NOP    = 32'h0000_0013;

   int checks = 0;
   int errors = 0;

   // Model: phase is what the core is doing this cycle
   // 0 = boot, 1 = running, 2 = entering trap, 3 = returning from trap
   int         m_phase;
   logic [3:0] m_cause;
   logic       m_irq;

   always #5 clk_in = ~clk_in;

   machine_control dut (
      .clk_in              (clk_in),
      .rst_n_in            (rst_n_in),
      .instr_in            (instr_in),
      .illegal_instr_in    (illegal_instr_in),
      .misaligned_load_in  (misaligned_load_in),
      .misaligned_store_in (misaligned_store_in),
      .misaligned_instr_in (misaligned_instr_in),
      .mie_in              (mie_in),
      .meie_in             (meie_in),
      .mtie_in             (mtie_in),
      .msie_in             (msie_in),
      .meip_in             (meip_in),
      .mtip_in             (mtip_in),
      .msip_in             (msip_in),
      .stall_in            (stall_in),
      .trap_taken_out      (trap_taken_out),
      .i_or_e_out          (i_or_e_out),
      .cause_out           (cause_out),
      .set_epc_out         (set_epc_out),
      .set_cause_out       (set_cause_out),
      .mie_clear_out       (mie_clear_out),
      .mie_set_out         (mie_set_out),
      .pc_src_out          (pc_src_out),
      .flush_out           (flush_out)
   );

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      checks++;
      assert (obs === exp) else begin
         errors++;
         $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
      end
   endtask

   // Highest-priority trap from the current inputs, by walking priority tables
   task automatic ref_trap(output bit valid, output bit irq, output logic [3:0] code);
      bit exc_f[6];
      int exc_c[6];
      bit irq_f[3];
      int irq_c[3];
      exc_f[0] = misaligned_instr_in;     exc_c[0] = 0;
      exc_f[1] = illegal_instr_in;        exc_c[1] = 2;
      exc_f[2] = (instr_in === EBREAK);   exc_c[2] = 3;
      exc_f[3] = (instr_in === ECALL);    exc_c[3] = 11;
      exc_f[4] = misaligned_load_in;      exc_c[4] = 4;
      exc_f[5] = misaligned_store_in;     exc_c[5] = 6;
      irq_f[0] = mie_in && meie_in && meip_in; irq_c[0] = 11;
      irq_f[1] = mie_in && msie_in && msip_in; irq_c[1] = 3;
      irq_f[2] = mie_in && mtie_in && mtip_in; irq_c[2] = 7;
      valid = 1'b0; irq = 1'b0; code = 4'd0;
      for (int i = 0; i < 6; i++)
         if (!valid && exc_f[i]) begin valid = 1'b1; code = 4'(exc_c[i]); end
      for (int i = 0; i < 3; i++)
         if (!valid && irq_f[i]) begin valid = 1'b1; irq = 1'b1; code = 4'(irq_c[i]); end
   endtask

   // Expected {trap_taken,set_epc,set_cause,mie_clear,mie_set,flush,pc_src}
   function automatic logic [7:0] exp_outs(input int phase);
      case (phase)
         0:       return 8'b0000_0100;
         2:       return 8'b1111_0110;
         3:       return 8'b0000_1101;
         default: return 8'b0000_0011;
      endcase
   endfunction

   task automatic check_all(input string tag);
      chk({tag, ".outs"}, {24'd0, trap_taken_out, set_epc_out, set_cause_out, mie_clear_out,
                           mie_set_out, flush_out, pc_src_out}, {24'd0, exp_outs(m_phase)});
      chk({tag, ".cause"}, {28'd0, cause_out}, {28'd0, m_cause});
      chk({tag, ".i_or_e"}, {31'd0, i_or_e_out}, {31'd0, m_irq});
   endtask

   // Advance one clock: model consumes the inputs the DUT sampled, then compare
   task automatic tick(input string tag);
      bit v, irq;
      logic [3:0] c;
      @(posedge clk_in);
      if (!rst_n_in) begin
         m_phase = 0; m_cause = 4'd0; m_irq = 1'b0;
      end else if (m_phase == 1) begin
         if (!stall_in) begin
            ref_trap(v, irq, c);
            if (v) begin
               m_phase = 2; m_cause = c; m_irq = irq;
            end else if (instr_in === MRET) begin
               m_phase = 3;
            end
         end
      end else begin
         m_phase = 1;
      end
      #1;
      check_all(tag);
   endtask

   task automatic clear_inputs();
      instr_in = NOP;
      illegal_instr_in = 0; misaligned_load_in = 0; misaligned_store_in = 0; misaligned_instr_in = 0;
      mie_in = 0; meie_in = 0; mtie_in = 0; msie_in = 0;
      meip_in = 0; mtip_in = 0; msip_in = 0;
      stall_in = 0;
   endtask

   initial begin
      clear_inputs();
      rst_n_in = 1'b0;
      m_phase = 0; m_cause = 4'd0; m_irq = 1'b0;

      // Reset release: low 3 cycles, one boot cycle, then running
      for (int i = 0; i < 3; i++) tick("reset_hold");
      rst_n_in = 1'b1;
      #1;
      check_all("reset_boot");
      chk("boot_pc_src", {30'd0, pc_src_out}, 32'd0);
      tick("reset_to_run");
      chk("run_pc_src", {30'd0, pc_src_out}, 32'd3);

      // ECALL
      instr_in = ECALL;
      tick("ecall_entry");
      chk("ecall_cause", {28'd0, cause_out}, 32'd11);
      chk("ecall_trap_taken", {31'd0, trap_taken_out}, 32'd1);
      instr_in = NOP;
      tick("ecall_vector");
      chk("ecall_after_pc_src", {30'd0, pc_src_out}, 32'd3);

      // Priority: exception beats interrupt, interrupt taken afterwards
      illegal_instr_in = 1; misaligned_load_in = 1;
      meip_in = 1; meie_in = 1; mie_in = 1;
      tick("prio_exc");
      chk("prio_exc_cause", {28'd0, cause_out}, 32'd2);
      illegal_instr_in = 0; misaligned_load_in = 0;
      tick("prio_back");
      tick("prio_irq");
      chk("prio_irq_cause", {27'd0, i_or_e_out, cause_out}, {27'd0, 1'b1, 4'd11});
      meip_in = 0; meie_in = 0; mie_in = 0;
      tick("prio_done");

      // Interrupt gating by mie_in
      mtip_in = 1; mtie_in = 1;
      for (int i = 0; i < 5; i++) tick("gate_blocked");
      mie_in = 1;
      tick("gate_open");
      chk("gate_cause", {28'd0, cause_out}, 32'd7);
      mtip_in = 0; mtie_in = 0; mie_in = 0;
      tick("gate_done");

      // MRET, then MRET pre-empted by a software interrupt
      instr_in = MRET;
      tick("mret_return");
      chk("mret_mie_set", {31'd0, mie_set_out}, 32'd1);
      instr_in = NOP;
      tick("mret_done");
      instr_in = MRET; msip_in = 1; msie_in = 1; mie_in = 1;
      tick("mret_vs_irq");
      chk("mret_vs_irq_cause", {28'd0, cause_out}, 32'd3);
      instr_in = NOP; msip_in = 0; msie_in = 0; mie_in = 0;
      tick("mret_vs_irq_done");

      // Stall freezes decisions; asynchronous reset during trap entry
      misaligned_store_in = 1; stall_in = 1;
      for (int i = 0; i < 4; i++) tick("stall_hold");
      stall_in = 0;
      tick("stall_release");
      chk("stall_cause", {28'd0, cause_out}, 32'd6);
      misaligned_store_in = 0;
      rst_n_in = 1'b0;
      #1;
      m_phase = 0; m_cause = 4'd0; m_irq = 1'b0;
      check_all("async_reset");
      tick("async_reset_hold");
      rst_n_in = 1'b1;
      tick("async_reset_run");

      // Back-to-back: an instruction at the vector that faults again
      misaligned_instr_in = 1;
      tick("b2b_first");
      tick("b2b_gap");
      tick("b2b_second");
      misaligned_instr_in = 0;
      tick("b2b_done");

      // Randomized traffic against the model
      for (int n = 0; n < 600; n++) begin
         case ($urandom_range(7))
            0:       instr_in = ECALL;
            1:       instr_in = EBREAK;
            2, 3:    instr_in = MRET;
            4:       instr_in = $urandom;
            default: instr_in = NOP;
         endcase
         illegal_instr_in    = ($urandom_range(9) == 0);
         misaligned_load_in  = ($urandom_range(9) == 0);
         misaligned_store_in = ($urandom_range(9) == 0);
         misaligned_instr_in = ($urandom_range(11) == 0);
         mie_in  = $urandom_range(1); meie_in = $urandom_range(1);
         mtie_in = $urandom_range(1); msie_in = $urandom_range(1);
         meip_in = ($urandom_range(3) == 0); mtip_in = ($urandom_range(3) == 0);
         msip_in = ($urandom_range(3) == 0);
         stall_in = ($urandom_range(3) == 0);
         tick("random");
      end

      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule

// File: doc/machine_control.md
# machine_control

Machine-mode trap sequencer for the RV32I core. It watches the decoder's exception flags, the fetched instruction and the interrupt pending/enable lines. It selects the highest-priority trap and sequences trap entry (EPC/cause capture, MIE clear, vector fetch) and MRET return (MIE restore, EPC fetch). It sits beside the decoder and drives the PC-source mux, the CSR-file update strobes and the pipeline flush.

## Interface
- Parameters: none. Cause codes, state encodings and PC-source encodings are fixed constants in the shared package.
- clk_in  input  1  core clock; all state updates on the rising edge
- rst_n_in  input  1  asynchronous, active-low reset
- instr_in  input  32  instruction in decode; used for ECALL/EBREAK/MRET detection
- illegal_instr_in  input  1  decoder illegal-instruction flag
- misaligned_load_in  input  1  decoder misaligned-load flag
- misaligned_store_in  input  1  decoder misaligned-store flag
- misaligned_instr_in  input  1  branch/jump target bits [1:0] != 0
- mie_in  input  1  mstatus.MIE
- meie_in / mtie_in / msie_in  input  1 each  mie enable bits
- meip_in / mtip_in / msip_in  input  1 each  pending interrupt lines, already synchronous to clk_in
- stall_in  input  1  memory not ready; freezes OPERATING decisions
- trap_taken_out  output  1  high during TRAP_TAKEN; drives the decoder's trap_taken_in
- i_or_e_out  output  1  registered: 1 = interrupt, 0 = exception
- cause_out  output  4  registered mcause code
- set_epc_out  output  1  mepc <= current PC
- set_cause_out  output  1  mcause <= {i_or_e_out, 27'b0, cause_out}
- mie_clear_out  output  1  mstatus.MPIE <= MIE, MIE <= 0
- mie_set_out  output  1  mstatus.MIE <= MPIE, MPIE <= 1
- pc_src_out  output  2  00 boot, 01 mepc, 10 trap vector, 11 next PC
- flush_out  output  1  kill the instruction in decode

## Operation
- Instruction detection, on exact 32-bit match:
  - ECALL = 32'h00000073
  - EBREAK = 32'h00100073
  - MRET = 32'h30200073
- States: RESET, OPERATING, TRAP_TAKEN, TRAP_RETURN; 2-bit registered state.
- Transitions:
  - RESET -> OPERATING unconditionally.
  - OPERATING with stall_in=1: hold state; no outputs change.
  - OPERATING, exception pending -> TRAP_TAKEN; latch cause and i_or_e=0.
  - OPERATING, no exception, mie_in=1 and any (xeie&xeip) -> TRAP_TAKEN; latch cause and i_or_e=1.
  - OPERATING, otherwise, MRET -> TRAP_RETURN.
  - OPERATING, otherwise: stay.
  - TRAP_TAKEN -> OPERATING.
  - TRAP_RETURN -> OPERATING. Neither trap state is affected by stall_in.
- Exception priority, highest first, with cause code:
  - misaligned_instr: 0
  - illegal: 2
  - EBREAK: 3
  - ECALL: 11
  - misaligned_load: 4
  - misaligned_store: 6
- Interrupt priority, highest first, with cause code: external 11, software 3, timer 7.
- Exceptions always win over interrupts. An interrupt is ignored while mie_in=0.
- Moore outputs by state:
  - RESET: pc_src=00, flush=1.
  - OPERATING: pc_src=11, all strobes 0.
  - TRAP_TAKEN: trap_taken, set_epc, set_cause, mie_clear, flush = 1; pc_src=10.
  - TRAP_RETURN: mie_set, flush = 1; pc_src=01.
- cause_out and i_or_e_out update only on entry to TRAP_TAKEN and hold otherwise.

## Timing
- Reset values: state=RESET, cause_out=0, i_or_e_out=0.
- Reset is asynchronous. Asserting rst_n_in in any state, including mid-TRAP_TAKEN, forces RESET immediately; outputs then read pc_src=00, flush=1, all strobes 0.
- Latency:
  - Trap condition sampled in OPERATING -> trap strobes high for exactly 1 cycle on the next cycle.
  - Next instruction fetched from the vector one cycle later.
  - MRET: same latency, via TRAP_RETURN.
- Simultaneous events:
  - Exception plus interrupt: the exception is taken and the interrupt stays pending; it is taken after return if still enabled.
  - MRET plus pending enabled interrupt: the interrupt is taken and MRET is not executed.
  - Exception asserted while stall_in=1: not acted on until stall_in falls.
- Back-to-back traps: the earliest new entry is the 2nd cycle after a trap. An instruction at the vector that itself faults re-enters TRAP_TAKEN.

## Structure
- Shared package `machine_control_pkg`: state encodings, PC_SRC_* encodings, CAUSE_* codes, ECALL/EBREAK/MRET instruction constants.
- One combinational sub-module, `trap_priority_enc`. It takes the exception flags, instruction matches and gated interrupts. It outputs trap_valid, is_interrupt and cause[3:0].
- The top module holds the FSM, the cause/i_or_e registers and the output decode.

## Test plan
- Reset release: rst_n_in low 3 cycles then high -> 1 cycle with pc_src=00, flush=1, then pc_src=11; cause_out=0.
- ECALL: instr_in=32'h00000073 in OPERATING -> next cycle trap_taken/set_epc/set_cause/mie_clear=1, pc_src=10, cause_out=11, i_or_e_out=0; cycle after that pc_src=11.
- Priority: illegal_instr_in=1 and misaligned_load_in=1 and meip&meie&mie=1 together -> cause_out=2, i_or_e_out=0. Interrupt then taken on the next OPERATING decision with cause 11, i_or_e=1.
- Interrupt gating: mtip=mtie=1, mie_in=0 for 5 cycles -> no trap. Raise mie_in -> trap next cycle, cause 7.
- MRET: instr_in=32'h30200073 -> TRAP_RETURN 1 cycle with mie_set=1, pc_src=01, flush=1. Repeat with msip&msie&mie=1 -> trap with cause 3 instead.
- Stall and reset: misaligned_store_in=1 with stall_in=1 for 4 cycles -> no trap; trap (cause 6) the cycle after stall_in falls. Assert rst_n_in during TRAP_TAKEN -> outputs go to reset values immediately.
